pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Control block that owns the 16-bit program counter and sequences instruction fetch. It runs a request/acknowledge handshake with instruction memory and accepts the decode outcome of each fetched instruction. It then selects the next PC: sequential, jump, branch, call, return, interrupt vector or halt. It sits between instruction memory and the decode stage, and replaces the bare load/reset PC register as the single source of fetch addresses.

## Interface
- ADDR_W, 16, PC and address width
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)
- RESET_VEC, 16'h0000, PC value after reset
- IRQ_VEC, 16'h0004, interrupt target address

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- run  in  1  level; permits fetching
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address; equals pc while imem_req=1
- imem_ack  in  1  fetch accepted; instruction available
- instr_valid  out  1  one-cycle pulse; instruction handed to decode
- dec_valid  in  1  decode outcome valid
- dec_kind  in  3  0 SEQ, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 HALT, 6–7 treated as SEQ
- dec_taken  in  1  branch condition; used for BRANCH only
- dec_target  in  ADDR_W  jump/branch/call target
- irq  in  1  level-sensitive interrupt request
- irq_ack  out  1  one-cycle pulse when interrupt taken
- pc  out  ADDR_W  current PC
- halted  out  1  high in HALTED
- ras_ovf  out  1  sticky; push onto full stack
- ras_unf  out  1  sticky; pop from empty stack

## Operation
- **States:** IDLE, FETCH, WAIT_DEC, HALTED.
- **IDLE:**
  - run=1 → FETCH.
  - irq is ignored.
- **FETCH:**
  - imem_req=1 and imem_addr=pc.
  - On imem_ack → WAIT_DEC.
- **WAIT_DEC:**
  - instr_valid is pulsed on entry.
  - The block waits for dec_valid, then computes next PC:
    - SEQ, or BRANCH with dec_taken=0: pc+1.
    - JUMP, or BRANCH with dec_taken=1: dec_target.
    - CALL: push pc+1; next = dec_target.
    - RET: pop; next = popped value. If the stack is empty: next = pc+1 and ras_unf is set.
    - HALT: go to HALTED; pc is unchanged.
  - **Interrupt:** if irq=1 at the same dec_valid and dec_kind ∉ {CALL, RET, HALT}:
    - push the computed next PC;
    - pc ← IRQ_VEC;
    - irq_ack is pulsed.
    - On CALL or RET the interrupt is deferred to the next completion.
  - After the update: go to FETCH if run=1, else IDLE.
- **HALTED:**
  - irq=1 → push pc+1, pc ← IRQ_VEC, irq_ack pulsed, then go to FETCH (or IDLE if run=0).
  - run has no effect in HALTED.
- **RAS behaviour:**
  - Circular buffer.
  - A push when full overwrites the oldest entry and sets ras_ovf.
  - Pops are LIFO.
- **Arithmetic:** pc+1 wraps modulo 2^ADDR_W, so 16'hFFFF → 16'h0000.
- **Ignored inputs:** dec_valid outside WAIT_DEC is ignored; imem_ack outside FETCH is ignored.

## Timing
- **Reset (async assert, sync deassert by the clock domain):**
  - pc=RESET_VEC, state IDLE;
  - imem_req, instr_valid, irq_ack, halted, ras_ovf, ras_unf all 0;
  - RAS empty.
- **Reset mid-operation:** an outstanding fetch is abandoned and imem_req drops immediately.
- **Handshake:**
  - imem_req rises the cycle after run is sampled high in IDLE.
  - imem_addr is stable until ack.
  - A zero-wait ack (same cycle as req) is legal.
- instr_valid is registered and high exactly the cycle after the ack edge.
- dec_valid may be high in that same cycle.
- **pc update:** on the dec_valid edge; the new pc is on imem_addr in the next cycle.
- **Throughput:** minimum 2 cycles per instruction (FETCH, WAIT_DEC).
- **Sticky flags:** ras_ovf and ras_unf clear only by reset.
- irq_ack is a single-cycle pulse; irq must deassert before the next completion or it is taken again.

## Structure
- Package pc_seq_pkg holds:
  - dec_kind encodings;
  - FSM state encodings;
  - default ADDR_W, RESET_VEC, IRQ_VEC.
- Sub-module pc_ras:
  - ports: push, pop, push_data, pop_data, empty, full;
  - circular pointer plus count;
  - parameterised by ADDR_W and RAS_DEPTH.
- Top-level pc_sequencer contains the FSM, the pc register and the next-PC mux.

## Test plan
- **Reset and sequential fetch:** reset, run=1, zero-wait ack, five SEQ outcomes → imem_addr 0,1,2,3,4,5; instr_valid pulses every 2 cycles.
- **Branch, jump and wrap:**
  - BRANCH taken, target 16'h0020 → next fetch at 0x0020.
  - BRANCH not taken at 0x0020 → 0x0021.
  - JUMP to 16'hFFFF, then SEQ → 0x0000.
- **Call/return nesting:**
  - CALLs at 0x10, 0x30, 0x50, 0x70, 0x90 (targets 0x30, 0x50, 0x70, 0x90, 0xB0) → ras_ovf=1.
  - Four RETs → 0x91, 0x71, 0x51, 0x31.
  - Fifth RET → ras_unf=1 and pc+1.
- **Interrupt:**
  - irq with SEQ completion at 0x40 → irq_ack pulse, fetch at 0x0004; a later RET → 0x41.
  - irq with a CALL completion → deferred one instruction.
- **Halt and wake:** HALT at 0x08 → halted=1, no imem_req for 10 cycles; irq → fetch 0x0004; RET → 0x09.
- **Reset and run control:**
  - run=0 during WAIT_DEC → IDLE after the update.
  - rst low while imem_req=1 with ack withheld → all outputs reset the same cycle, pc=RESET_VEC.

Source files
------------

// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// pc_seq_pkg
// Shared encodings and default parameters for the PC sequencer.
// Revision: 1.0
// ============================================================================
package pc_seq_pkg;

  localparam int          c_addr_w_def    = 16;
  localparam logic [15:0] c_reset_vec_def = 16'h0000;
  localparam logic [15:0] c_irq_vec_def   = 16'h0004;

  // Decode outcome encodings; 6 and 7 fall back to sequential.
  localparam logic [2:0] c_kind_seq    = 3'd0;
  localparam logic [2:0] c_kind_jump   = 3'd1;
  localparam logic [2:0] c_kind_branch = 3'd2;
  localparam logic [2:0] c_kind_call   = 3'd3;
  localparam logic [2:0] c_kind_ret    = 3'd4;
  localparam logic [2:0] c_kind_halt   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_WAIT_DEC = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pc_seq_if.sv
`default_nettype none
// ============================================================================
// pc_seq_if
// Instruction-memory fetch handshake and decode-outcome bus.
// Revision: 1.0
// ============================================================================
interface pc_seq_if #(
  parameter int ADDR_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic              instr_valid;
  logic              dec_valid;
  logic [2:0]        dec_kind;
  logic              dec_taken;
  logic [ADDR_W-1:0] dec_target;

  modport master (
    output imem_req, imem_addr, instr_valid,
    input  imem_ack, dec_valid, dec_kind, dec_taken, dec_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid,
    output imem_ack, dec_valid, dec_kind, dec_taken, dec_target
  );
endinterface
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// pc_ras
// Circular return-address stack; a push when full overwrites the oldest entry.
// Revision: 1.0
// ============================================================================
module pc_ras #(
  parameter int ADDR_W    = 16,
  parameter int RAS_DEPTH = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              push,
  input  wire logic              pop,
  input  wire logic [ADDR_W-1:0] push_data,
  output logic      [ADDR_W-1:0] pop_data,
  output logic                   empty,
  output logic                   full
);
  localparam int                c_ptr_w = $clog2(RAS_DEPTH);
  localparam logic [c_ptr_w:0]  c_full  = (c_ptr_w+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0]  r_mem [RAS_DEPTH];
  logic [c_ptr_w-1:0] r_wp;
  logic [c_ptr_w:0]   r_cnt;
  logic [c_ptr_w-1:0] w_rd_ptr;

  assign w_rd_ptr = r_wp - c_ptr_w'(1);
  assign pop_data = r_mem[w_rd_ptr];
  assign empty    = (r_cnt == '0);
  assign full     = (r_cnt == c_full);

  // When full, the write pointer already sits on the oldest entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_cnt <= '0;
    end else if (push) begin
      r_wp <= r_wp + c_ptr_w'(1);
      if (!full) r_cnt <= r_cnt + 1'b1;
    end else if (pop && !empty) begin
      r_wp  <= w_rd_ptr;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wp] <= push_data;
  end
endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer
// Owns the program counter, runs the fetch handshake and selects the next PC.
// Revision: 1.0
// ============================================================================
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W    = c_addr_w_def,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(c_reset_vec_def),
  parameter logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'(c_irq_vec_def)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              run,
  pc_seq_if.master               bus,
  input  wire logic              irq,
  output logic                   irq_ack,
  output logic      [ADDR_W-1:0] pc,
  output logic                   halted,
  output logic                   ras_ovf,
  output logic                   ras_unf
);
  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt, w_pc_inc, w_push_data, w_pop_data;
  logic              r_instr_valid, w_iv_nxt;
  logic              r_irq_ack, w_ack_nxt;
  logic              r_ras_ovf, r_ras_unf, w_unf_set;
  logic              w_push, w_pop, w_empty, w_full, w_irq_ok;

  pc_ras #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_push_data),
    .pop_data  (w_pop_data),
    .empty     (w_empty),
    .full      (w_full)
  );

  assign w_pc_inc        = r_pc + ADDR_W'(1);
  assign bus.imem_req    = (r_state == ST_FETCH);
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = r_instr_valid;
  assign pc              = r_pc;
  assign halted          = (r_state == ST_HALTED);
  assign irq_ack         = r_irq_ack;
  assign ras_ovf         = r_ras_ovf;
  assign ras_unf         = r_ras_unf;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_push_data = w_pc_inc;
    w_iv_nxt    = 1'b0;
    w_ack_nxt   = 1'b0;
    w_unf_set   = 1'b0;
    w_irq_ok    = 1'b0;
    case (r_state)
      ST_IDLE: if (run) w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (bus.imem_ack) begin
          w_state_nxt = ST_WAIT_DEC;
          w_iv_nxt    = 1'b1;
        end
      end
      ST_WAIT_DEC: begin
        if (bus.dec_valid) begin
          w_state_nxt = run ? ST_FETCH : ST_IDLE;
          case (bus.dec_kind)
            c_kind_seq: begin
              w_pc_nxt = w_pc_inc;
              w_irq_ok = 1'b1;
            end
            c_kind_jump: begin
              w_pc_nxt = bus.dec_target;
              w_irq_ok = 1'b1;
            end
            c_kind_branch: begin
              w_pc_nxt = bus.dec_taken ? bus.dec_target : w_pc_inc;
              w_irq_ok = 1'b1;
            end
            c_kind_call: begin
              w_push   = 1'b1;
              w_pc_nxt = bus.dec_target;
            end
            c_kind_ret: begin
              if (w_empty) begin
                w_unf_set = 1'b1;
                w_pc_nxt  = w_pc_inc;
              end else begin
                w_pop    = 1'b1;
                w_pc_nxt = w_pop_data;
              end
            end
            c_kind_halt: w_state_nxt = ST_HALTED;
            default: begin
              w_pc_nxt = w_pc_inc;
              w_irq_ok = 1'b1;
            end
          endcase
          // The interrupt return address is the PC this instruction would have chosen.
          if (w_irq_ok && irq) begin
            w_push      = 1'b1;
            w_push_data = w_pc_nxt;
            w_pc_nxt    = IRQ_VEC;
            w_ack_nxt   = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        if (irq) begin
          w_push      = 1'b1;
          w_pc_nxt    = IRQ_VEC;
          w_ack_nxt   = 1'b1;
          w_state_nxt = run ? ST_FETCH : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_VEC;
      r_instr_valid <= 1'b0;
      r_irq_ack     <= 1'b0;
      r_ras_ovf     <= 1'b0;
      r_ras_unf     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr_valid <= w_iv_nxt;
      r_irq_ack     <= w_ack_nxt;
      r_ras_ovf     <= r_ras_ovf | (w_push & w_full);
      r_ras_unf     <= r_ras_unf | w_unf_set;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pc_sequencer
// Self-checking bench: directed scenarios plus randomized instruction stream.
// Revision: 1.0
// ============================================================================
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        irq = 1'b0;
  logic        irq_ack, halted, ras_ovf, ras_unf;
  logic [15:0] pc;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          iv_cyc   = 0;

  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  bit          m_ovf, m_unf, m_halted;

  pc_seq_if #(.ADDR_W(16)) bus ();

  pc_sequencer #(.ADDR_W(16), .RAS_DEPTH(4), .RESET_VEC(16'h0000), .IRQ_VEC(16'h0004)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .bus     (bus),
    .irq     (irq),
    .irq_ack (irq_ack),
    .pc      (pc),
    .halted  (halted),
    .ras_ovf (ras_ovf),
    .ras_unf (ras_unf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_pc = 16'h0000;
    m_stk.delete();
    m_ovf = 0; m_unf = 0; m_halted = 0;
  endtask

  task automatic m_push(input logic [15:0] v);
    if (m_stk.size() == 4) begin
      m_ovf = 1;
      void'(m_stk.pop_front());
    end
    m_stk.push_back(v);
  endtask

  // Reference: applies one decode outcome, returns whether the irq is taken.
  task automatic m_step(input logic [2:0] kind, input bit taken, input logic [15:0] tgt,
                        input bit irq_in, output bit took_irq);
    logic [15:0] nxt;
    int k;
    k = (kind > 3'd5) ? 0 : int'(kind);
    nxt = m_pc + 16'd1;
    took_irq = 0;
    if (k == 1 || (k == 2 && taken)) nxt = tgt;
    if (k == 3) begin m_push(m_pc + 16'd1); nxt = tgt; end
    if (k == 4) begin
      if (m_stk.size() == 0) m_unf = 1;
      else nxt = m_stk.pop_back();
    end
    if (k == 5) begin m_halted = 1; nxt = m_pc; end
    if (irq_in && k <= 2) begin
      m_push(nxt);
      nxt = 16'h0004;
      took_irq = 1;
    end
    m_pc = nxt;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 30; i++) begin
      if (bus.imem_req) break;
      @(negedge clk);
    end
    chk("req_timeout", {31'd0, bus.imem_req}, 32'd1);
  endtask

  task automatic do_instr(input logic [2:0] kind, input bit taken, input logic [15:0] tgt,
                          input bit irq_in, input int ack_dly, input int dec_dly, input bit run_dec);
    bit took;
    run = 1'b1;
    wait_req();
    chk("imem_addr", {16'd0, bus.imem_addr}, {16'd0, m_pc});
    repeat (ack_dly) begin
      bus.dec_valid  = 1'($urandom_range(0, 1));
      bus.dec_kind   = 3'd1;
      bus.dec_target = 16'hDEAD;
      @(negedge clk);
      chk("addr_stable", {16'd0, bus.imem_addr}, {16'd0, m_pc});
    end
    bus.dec_valid = 1'b0;
    bus.imem_ack  = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("instr_valid", {31'd0, bus.instr_valid}, 32'd1);
    iv_cyc = cyc;
    repeat (dec_dly) begin
      bus.imem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("iv_single", {31'd0, bus.instr_valid}, 32'd0);
    end
    bus.imem_ack   = 1'b0;
    bus.dec_valid  = 1'b1;
    bus.dec_kind   = kind;
    bus.dec_taken  = taken;
    bus.dec_target = tgt;
    irq = irq_in;
    run = run_dec;
    @(negedge clk);
    bus.dec_valid = 1'b0;
    irq = 1'b0;
    m_step(kind, taken, tgt, irq_in, took);
    chk("irq_ack", {31'd0, irq_ack}, {31'd0, took});
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("pc", {16'd0, pc}, {16'd0, m_pc});
    chk("ras_ovf", {31'd0, ras_ovf}, {31'd0, m_ovf});
    chk("ras_unf", {31'd0, ras_unf}, {31'd0, m_unf});
    chk("req_after", {31'd0, bus.imem_req}, {31'd0, run_dec && !m_halted});
    run = 1'b1;
  endtask

  task automatic wake();
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    m_push(m_pc + 16'd1);
    m_pc = 16'h0004;
    m_halted = 0;
    chk("wake_ack", {31'd0, irq_ack}, 32'd1);
    chk("wake_halted", {31'd0, halted}, 32'd0);
    chk("wake_pc", {16'd0, pc}, {16'd0, m_pc});
  endtask

  initial begin
    int prev;
    bus.imem_ack = 1'b0; bus.dec_valid = 1'b0; bus.dec_kind = 3'd0;
    bus.dec_taken = 1'b0; bus.dec_target = 16'h0000;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("rst_pc", {16'd0, pc}, 32'd0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_iv", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_flags", {28'd0, irq_ack, halted, ras_ovf, ras_unf}, 32'd0);

    // Sequential fetch with zero-wait ack.
    for (int i = 0; i < 5; i++) begin
      prev = iv_cyc;
      do_instr(3'd0, 0, 16'h0, 0, 0, 0, 1);
      if (i > 0) chk("iv_period", iv_cyc - prev, 32'd2);
    end
    // Branch, jump and wrap.
    do_instr(3'd2, 1, 16'h0020, 0, 0, 0, 1);
    do_instr(3'd2, 0, 16'h0099, 0, 1, 1, 1);
    do_instr(3'd1, 0, 16'hFFFF, 0, 0, 0, 1);
    do_instr(3'd0, 0, 16'h0, 0, 0, 0, 1);
    chk("wrap_pc", {16'd0, pc}, 32'd0);
    // Call nesting beyond the stack depth, then unwinding.
    do_instr(3'd1, 0, 16'h0010, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) do_instr(3'd3, 0, 16'h0030 + 16'(i * 32), 0, 0, 0, 1);
    chk("ovf_set", {31'd0, ras_ovf}, 32'd1);
    for (int i = 0; i < 5; i++) do_instr(3'd4, 0, 16'h0, 0, 0, 0, 1);
    chk("unf_pc", {16'd0, pc}, 32'h32);
    // Interrupt on SEQ, return, then deferral across a CALL.
    do_instr(3'd1, 0, 16'h0040, 0, 0, 0, 1);
    do_instr(3'd0, 0, 16'h0, 1, 0, 0, 1);
    do_instr(3'd4, 0, 16'h0, 0, 0, 0, 1);
    chk("irq_ret", {16'd0, pc}, 32'h41);
    do_instr(3'd3, 0, 16'h0060, 1, 0, 0, 1);
    do_instr(3'd0, 0, 16'h0, 1, 0, 0, 1);
    do_instr(3'd4, 0, 16'h0, 0, 0, 0, 1);
    do_instr(3'd4, 0, 16'h0, 0, 0, 0, 1);
    // Halt, stay quiet, wake on irq.
    do_instr(3'd1, 0, 16'h0008, 0, 0, 0, 1);
    do_instr(3'd5, 0, 16'h0, 0, 0, 0, 1);
    repeat (10) begin
      @(negedge clk);
      chk("halt_quiet", {30'd0, bus.imem_req, halted}, 32'd1);
    end
    wake();
    do_instr(3'd4, 0, 16'h0, 0, 0, 0, 1);
    chk("halt_ret", {16'd0, pc}, 32'h9);
    // run=0 at completion parks in IDLE; irq is ignored there.
    do_instr(3'd0, 0, 16'h0, 0, 0, 0, 0);
    run = 1'b0; irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    @(negedge clk);
    chk("idle_noack", {30'd0, irq_ack, bus.imem_req}, 32'd0);
    chk("idle_pc", {16'd0, pc}, {16'd0, m_pc});

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      do_instr(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom),
               ($urandom_range(0, 4) == 0), $urandom_range(0, 2), $urandom_range(0, 2),
               ($urandom_range(0, 3) != 0));
      if (m_halted) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        wake();
      end
    end

    // Asynchronous reset while a fetch is outstanding.
    run = 1'b1;
    wait_req();
    #2 rst = 1'b0;
    #1;
    chk("arst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("arst_pc", {16'd0, pc}, 32'd0);
    chk("arst_flags", {27'd0, bus.instr_valid, irq_ack, halted, ras_ovf, ras_unf}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    do_instr(3'd4, 0, 16'h0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
